product_accumulator: RTL and testbench

- Downstream consumer of the array multiplier pipeline.
- Takes the registered product stream (Z_final / o_valid) and sums products in groups of VEC_LEN, or fewer when i_last ends a group early.
- Emits one dot-product result per vector with a one-cycle valid pulse.
- Unsigned arithmetic with guard bits and saturation on overflow.

---
 rtl/product_accumulator.sv | 105 ++++++++++
 tb/tb_product_accumulator.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Sums a stream of unsigned multiplier products into a dot product for each vector.
// A vector closes after VEC_LEN products, or sooner when i_last is set. The result
// is registered and o_valid pulses for one cycle. The sum saturates to all-ones
// when the guard bits are exhausted.
module product_accumulator #(
  parameter int DATAWIDTH   = 16,
  parameter int VEC_LEN     = 4,
  parameter int GUARD_BITS  = 4,
  parameter int INSTANCE_ID = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_valid,
  input  logic [2*DATAWIDTH-1:0]                i_product,
  input  logic                                  i_last,
  output logic [2*DATAWIDTH+GUARD_BITS-1:0]     o_sum,
  output logic [$clog2(VEC_LEN+1)-1:0]          o_count,
  output logic                                  o_overflow,
  output logic                                  o_valid
);

  localparam int PROD_W    = 2 * DATAWIDTH;
  localparam int ACC_WIDTH = PROD_W + GUARD_BITS;
  localparam int CNT_W     = $clog2(VEC_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

  // INSTANCE_ID is only a trace tag; it is checked here so that a bad value is caught.
  if (VEC_LEN < 1 || INSTANCE_ID < 0) begin : g_bad_params
    $error("product_accumulator: VEC_LEN must be >= 1 and INSTANCE_ID >= 0");
  end

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                  state, state_next;
  logic [ACC_WIDTH-1:0]    acc;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf;

  logic [ACC_WIDTH-1:0]    nsum_p0;
  logic                    sat_p0;
  logic                    close_p0;

  // Add one product to the running sum. The carry out of the ACC_WIDTH-bit sum,
  // or an overflow already seen earlier in the vector, forces the sum to all-ones.
  // The result is returned as {sat, sum}.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [PROD_W-1:0]    p,
                                                 input logic                 ovf_in);
    logic [ACC_WIDTH:0] wide;
    logic               s;
    wide = {1'b0, a} + {{(GUARD_BITS+1){1'b0}}, p};
    s    = ovf_in | wide[ACC_WIDTH];
    return {s, s ? {ACC_WIDTH{1'b1}} : wide[ACC_WIDTH-1:0]};
  endfunction

  // Accept path and close decision, plus the next state of the FSM.
  always_comb begin
    state_next           = state;
    {sat_p0, nsum_p0}    = sat_add(acc, i_product, ovf);
    close_p0             = i_last | (cnt == LAST_CNT);
    if (i_valid) begin
      state_next = close_p0 ? IDLE : ACCUM;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Accumulator, counter, and registered result. This is stage p1.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      o_sum      <= '0;
      o_count    <= '0;
      o_overflow <= 1'b0;
      o_valid    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_valid) begin
        if (close_p0) begin
          o_sum      <= nsum_p0;
          o_count    <= cnt + CNT_W'(1);
          o_overflow <= sat_p0;
          o_valid    <= 1'b1;
          acc        <= '0;
          cnt        <= '0;
          ovf        <= 1'b0;
        end else begin
          acc <= nsum_p0;
          cnt <= cnt + CNT_W'(1);
          ovf <= sat_p0;
        end
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator. It uses three instances: the default
// configuration, GUARD_BITS=1 for saturation, and VEC_LEN=1.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_product = '0;
  logic        i_last = 1'b0;

  logic [35:0] sum0;  logic [2:0] cnt0;  logic ovf0;  logic vld0;
  logic [32:0] sum1;  logic [2:0] cnt1;  logic ovf1;  logic vld1;
  logic [35:0] sum2;  logic [0:0] cnt2;  logic ovf2;  logic vld2;

  int checks = 0;
  int failures = 0;
  int vcnt = 0;

  always #5 clk = ~clk;

  product_accumulator #(.DATAWIDTH(16), .VEC_LEN(4), .GUARD_BITS(4), .INSTANCE_ID(0)) d0 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_product(i_product), .i_last(i_last),
    .o_sum(sum0), .o_count(cnt0), .o_overflow(ovf0), .o_valid(vld0));

  product_accumulator #(.DATAWIDTH(16), .VEC_LEN(4), .GUARD_BITS(1), .INSTANCE_ID(1)) d1 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_product(i_product), .i_last(i_last),
    .o_sum(sum1), .o_count(cnt1), .o_overflow(ovf1), .o_valid(vld1));

  product_accumulator #(.DATAWIDTH(16), .VEC_LEN(1), .GUARD_BITS(4), .INSTANCE_ID(2)) d2 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_product(i_product), .i_last(i_last),
    .o_sum(sum2), .o_count(cnt2), .o_overflow(ovf2), .o_valid(vld2));

  // Count the result pulses of the default instance.
  always @(negedge clk) if (vld0) vcnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] p, input logic l);
    i_valid   = v;
    i_product = p;
    i_last    = l;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 32'd0, 1'b0);
    rst = 1'b0;
  endtask

  int v0;

  initial begin
    // Reset state
    do_reset();
    chk("rst_sum", sum0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_vld", vld0, 0);

    // Full vector
    v0 = vcnt;
    step(1, 65025, 0);  chk("full_v1", vld0, 0);
    step(1, 2550, 0);   chk("full_v2", vld0, 0);
    step(1, 54288, 0);  chk("full_v3", vld0, 0);
    chk("vl1_sum", sum2, 54288);
    chk("vl1_cnt", cnt2, 1);
    chk("vl1_vld", vld2, 1);
    step(1, 0, 0);
    chk("full_vld", vld0, 1);
    chk("full_sum", sum0, 121863);
    chk("full_cnt", cnt0, 4);
    chk("full_ovf", ovf0, 0);
    step(0, 0, 0);
    chk("full_pulse_end", vld0, 0);
    chk("full_hold", sum0, 121863);
    chk("full_npulse", vcnt, v0 + 1);

    // Early close with bubbles. i_last is ignored while i_valid is low.
    v0 = vcnt;
    step(1, 10, 0);
    step(0, 0, 1);
    chk("bub_vld", vld0, 0);
    step(0, 0, 0);
    step(1, 20, 1);
    chk("early_vld", vld0, 1);
    chk("early_sum", sum0, 30);
    chk("early_cnt", cnt0, 2);
    step(0, 0, 0);
    chk("early_npulse", vcnt, v0 + 1);

    // Back-to-back vectors
    for (int i = 1; i <= 8; i++) begin
      step(1, i, 0);
      if (i == 4) begin
        chk("b2b_vld_a", vld0, 1); chk("b2b_sum_a", sum0, 10); chk("b2b_cnt_a", cnt0, 4);
      end
      if (i == 5) chk("b2b_gap", vld0, 0);
      if (i == 8) begin
        chk("b2b_vld_b", vld0, 1); chk("b2b_sum_b", sum0, 26); chk("b2b_cnt_b", cnt0, 4);
      end
    end
    step(0, 0, 0);
    chk("b2b_hold", sum0, 26);
    chk("b2b_idle_vld", vld0, 0);

    // Saturation on the GUARD_BITS=1 instance. The default instance still has headroom.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 32'hFFFF_FFFF, 0);
    chk("sat_vld", vld1, 1);
    chk("sat_sum", sum1, 33'h1_FFFF_FFFF);
    chk("sat_ovf", ovf1, 1);
    chk("sat_cnt", cnt1, 4);
    chk("wide_sum", sum0, 36'h3_FFFF_FFFC);
    chk("wide_ovf", ovf0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    chk("sat_clr_sum", sum1, 4);
    chk("sat_clr_ovf", ovf1, 0);

    // Reset in the middle of a vector
    step(1, 100, 0);
    step(1, 200, 0);
    v0 = vcnt;
    rst = 1'b1;
    step(1, 300, 0);
    rst = 1'b0;
    chk("mid_rst_vld", vld0, 0);
    chk("mid_rst_sum", sum0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    chk("mid_vld", vld0, 1);
    chk("mid_sum", sum0, 4);
    chk("mid_cnt", cnt0, 4);
    step(0, 0, 0);
    chk("mid_npulse", vcnt, v0 + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
